// File: rtl/ld3320_bus_responder.sv
// LD3320 chip-side bus responder: register file, keyword FIFO behind 0x05,
// and the 0xB2 busy/idle status register, driven by A0/CSB/WRB/RDB plus P.
//
// Handshake: the bus pins are sampled each clk. A write transfers on the
// registered WRB rising edge (WRB_d=0 and WRB=1 while CSB_d=0), using P_d as
// the data and A0_d as the phase. A read completes on the registered RDB
// rising edge. Read data is driven combinationally while CSB=0, RDB=0, A0=0.
module ld3320_bus_responder #(
  parameter int BUSY_CYCLES = 64,
  parameter int KW_DEPTH    = 64
) (
  input  logic                        clk,
  input  logic                        sys_rstn,
  inout  wire logic [7:0]             P,
  input  logic                        A0,
  input  logic                        CSB,
  input  logic                        WRB,
  input  logic                        RDB,
  output logic                        busy,
  output logic [$clog2(KW_DEPTH):0]   kw_count,
  output logic [7:0]                  kw_code,
  output logic                        commit,
  output logic                        len_err,
  output logic                        proto_err,
  output logic [1:0]                  o_dbg_state,
  output logic [7:0]                  o_dbg_kw_head
);

  localparam int KW_AW = $clog2(KW_DEPTH);
  localparam int CW    = KW_AW + 1;
  localparam int BCW   = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_wrb_d;
  logic              r_rdb_d;
  logic              r_csb_d;
  logic              r_a0_d;
  logic [7:0]        r_p_d;

  logic [7:0]        r_addr;
  logic [7:0]        r_regs [256];
  logic [7:0]        r_kw_mem [KW_DEPTH];
  logic [KW_AW-1:0]  r_kw_wptr;
  logic [CW-1:0]     r_kw_count;
  logic [7:0]        r_kw_code;
  logic [BCW-1:0]    r_busy_cnt;
  logic              r_commit;
  logic              r_len_err;
  logic              r_proto_err;

  logic              w_wr_evt;
  logic              w_rd_evt;
  logic              w_rd_req;
  logic              w_addr_we;
  logic              w_reg_we;
  logic              w_proto_set;
  logic              w_kw_full;
  logic              w_kw_push;
  logic              w_kw_overflow;
  logic              w_kw_clear;
  logic              w_commit_evt;
  logic              w_busy;
  logic [7:0]        w_rd_data;

  assign w_wr_evt = ~r_wrb_d & WRB & ~r_csb_d;
  assign w_rd_evt = ~r_rdb_d & RDB & ~r_csb_d;
  assign w_rd_req = ~CSB & ~RDB & ~A0;

  // Pin sampling registers; idle values match an undriven, deselected bus.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_wrb_d <= 1'b1;
      r_rdb_d <= 1'b1;
      r_csb_d <= 1'b1;
      r_a0_d  <= 1'b0;
      r_p_d   <= 8'h00;
    end else begin
      r_wrb_d <= WRB;
      r_rdb_d <= RDB;
      r_csb_d <= CSB;
      r_a0_d  <= A0;
      r_p_d   <= P;
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Bus FSM next state and per-cycle action strobes.
  always_comb begin
    w_next      = r_state;
    w_addr_we   = 1'b0;
    w_reg_we    = 1'b0;
    w_proto_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_evt) begin
          if (r_a0_d) begin
            w_addr_we = 1'b1;
            w_next    = ST_ADDR;
          end else begin
            w_proto_set = 1'b1;
          end
        end else if (w_rd_req) begin
          w_proto_set = 1'b1;
        end
      end
      ST_ADDR: begin
        if (w_wr_evt) begin
          if (r_a0_d) begin
            w_addr_we = 1'b1;
          end else begin
            w_reg_we = 1'b1;
            w_next   = ST_IDLE;
          end
        end else if (w_rd_req) begin
          w_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_wr_evt) begin
          w_proto_set = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_rd_evt) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_kw_full     = (r_kw_count == CW'(KW_DEPTH));
  assign w_kw_push     = w_reg_we && (r_addr == 8'h05) && !w_kw_full;
  assign w_kw_overflow = w_reg_we && (r_addr == 8'h05) && w_kw_full;
  assign w_kw_clear    = w_reg_we && (r_addr == 8'h08) && r_p_d[2];
  assign w_commit_evt  = w_reg_we && (r_addr == 8'h37);
  assign w_busy        = (r_busy_cnt != '0);

  // Address latch.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn)      r_addr <= 8'h00;
    else if (w_addr_we) r_addr <= r_p_d;
  end

  // Register file; every data-phase write lands here, including 0xB2.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 0; i < 256; i++) r_regs[i] <= 8'h00;
    end else if (w_reg_we) begin
      r_regs[r_addr] <= r_p_d;
    end
  end

  // Keyword FIFO storage; contents only matter below the write pointer.
  always_ff @(posedge clk) begin
    if (w_kw_push) r_kw_mem[r_kw_wptr] <= r_p_d;
  end

  // Keyword FIFO pointer and count; a clear always takes priority.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_kw_wptr  <= '0;
      r_kw_count <= '0;
    end else if (w_kw_clear) begin
      r_kw_wptr  <= '0;
      r_kw_count <= '0;
    end else if (w_kw_push) begin
      r_kw_wptr  <= r_kw_wptr + KW_AW'(1);
      r_kw_count <= r_kw_count + CW'(1);
    end
  end

  // Keyword code, commit pulse and busy countdown.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_kw_code  <= 8'h00;
      r_commit   <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      r_commit <= w_commit_evt;
      if (w_reg_we && (r_addr == 8'hC1)) r_kw_code <= r_p_d;
      if (w_commit_evt)  r_busy_cnt <= BCW'(BUSY_CYCLES);
      else if (w_busy)   r_busy_cnt <= r_busy_cnt - BCW'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_len_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_commit_evt && (r_regs[8'hB9] != 8'(r_kw_count))) r_len_err <= 1'b1;
      if (w_proto_set || w_kw_overflow) r_proto_err <= 1'b1;
    end
  end

  // Status register 0xB2 reports 0x21 when idle and 0x00 while busy.
  always_comb begin
    w_rd_data = r_regs[r_addr];
    if (r_addr == 8'hB2) w_rd_data = w_busy ? 8'h00 : 8'h21;
  end

  assign P = (sys_rstn && w_rd_req) ? w_rd_data : 8'hzz;

  assign busy          = w_busy;
  assign kw_count      = r_kw_count;
  assign kw_code       = r_kw_code;
  assign commit        = r_commit;
  assign len_err       = r_len_err;
  assign proto_err     = r_proto_err;
  assign o_dbg_state   = r_state;
  assign o_dbg_kw_head = r_kw_mem[0];

endmodule

// File: tb/tb_ld3320_bus_responder.sv
// Directed bench for ld3320_bus_responder: host-side bus driver tasks, a
// transaction-level model of the chip registers, and a per-cycle compare.
module tb_ld3320_bus_responder;

  localparam int BUSY = 64;
  localparam int KWD  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rstn = 1'b0;
  always #5 clk = ~clk;

  logic       A0 = 1'b1, CSB = 1'b1, WRB = 1'b1, RDB = 1'b1;
  logic       drv_en = 1'b0;
  logic [7:0] p_drv = 8'h00;
  wire  [7:0] P;
  assign P = drv_en ? p_drv : 8'hzz;

  logic       busy, commit, len_err, proto_err;
  logic [6:0] kw_count;
  logic [7:0] kw_code, dbg_kw_head;
  logic [1:0] dbg_state;

  ld3320_bus_responder #(.BUSY_CYCLES(BUSY), .KW_DEPTH(KWD)) dut (
    .clk(clk), .sys_rstn(sys_rstn), .P(P), .A0(A0), .CSB(CSB), .WRB(WRB),
    .RDB(RDB), .busy(busy), .kw_count(kw_count), .kw_code(kw_code),
    .commit(commit), .len_err(len_err), .proto_err(proto_err),
    .o_dbg_state(dbg_state), .o_dbg_kw_head(dbg_kw_head)
  );

  // ---------------- scoreboard / model ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int busy_end = 0;
  int commit_cyc = -1;
  int commit_pulses = 0;
  bit cmp_en = 1'b0;

  logic [7:0] m_reg [256];
  logic [7:0] m_kw [$];
  logic [7:0] m_addr = 8'h00;
  bit         m_have = 1'b0;
  logic [7:0] m_kw_code = 8'h00;
  bit         m_len = 1'b0;
  bit         m_proto = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd();
    if (m_addr == 8'hB2) return (cyc < busy_end) ? 8'h00 : 8'h21;
    return m_reg[m_addr];
  endfunction

  // Apply one completed host write to the model.
  task automatic model_wr(input logic a0, input logic [7:0] d);
    if (a0) begin
      m_addr = d;
      m_have = 1'b1;
    end else if (!m_have) begin
      m_proto = 1'b1;
    end else begin
      m_have = 1'b0;
      case (m_addr)
        8'h05: if (m_kw.size() == KWD) m_proto = 1'b1; else m_kw.push_back(d);
        8'h08: if (d[2]) m_kw.delete();
        8'hC1: m_kw_code = d;
        8'h37: begin
          commit_cyc = cyc;
          busy_end   = cyc + BUSY;
          if (m_reg[8'hB9] != 8'(m_kw.size())) m_len = 1'b1;
        end
        default: ;
      endcase
      m_reg[m_addr] = d;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (commit) commit_pulses++;
      check("kw_count", 32'(kw_count), 32'(m_kw.size()));
      check("kw_code", 32'(kw_code), 32'(m_kw_code));
      check("busy", 32'(busy), 32'(cyc < busy_end));
      check("commit", 32'(commit), 32'(cyc == commit_cyc));
      check("len_err", 32'(len_err), 32'(m_len));
      check("proto_err", 32'(proto_err), 32'(m_proto));
      if (m_kw.size() > 0) check("kw_head", 32'(dbg_kw_head), 32'(m_kw[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_wr(input logic a0, input logic [7:0] d);
    @(negedge clk);
    A0 = a0; p_drv = d; drv_en = 1'b1; CSB = 1'b0; WRB = 1'b0;
    @(negedge clk);
    WRB = 1'b1;
    @(posedge clk);
    #1 model_wr(a0, d);
    @(negedge clk);
    CSB = 1'b1; drv_en = 1'b0; A0 = 1'b1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    bus_wr(1'b1, a);
    bus_wr(1'b0, d);
  endtask

  task automatic bus_rd(output logic [7:0] got);
    @(negedge clk);
    A0 = 1'b0; CSB = 1'b0; RDB = 1'b0;
    #1 got = P;
    if (m_have) check("read_P", 32'(got), 32'(model_rd()));
    @(posedge clk);
    #1 if (!m_have) m_proto = 1'b1;
    @(negedge clk);
    RDB = 1'b1;
    @(posedge clk);
    #1 m_have = 1'b0;
    @(negedge clk);
    CSB = 1'b1; A0 = 1'b1;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] got);
    bus_wr(1'b1, a);
    bus_rd(got);
  endtask

  task automatic load_keywords(input int n, input logic [7:0] b9);
    reg_wr(8'h08, 8'h04);
    for (int i = 0; i < n; i++) reg_wr(8'h05, 8'(8'h10 + i));
    reg_wr(8'hB9, b9);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    int n;
    int pulses0;
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;

    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (P !== 8'hzz) begin
      tests_failed++;
      $display("FAIL reset_P: got %0h expected zz", P);
    end
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_kw_count", 32'(kw_count), 32'd0);
    check("reset_kw_code", 32'(kw_code), 32'd0);
    check("reset_flags", {29'd0, commit, len_err, proto_err}, 32'd0);
    cmp_en = 1'b1;

    // Keyword code write and readback.
    reg_wr(8'hC1, 8'h01);
    reg_rd(8'hC1, rd);
    check("lit_rd_C1", 32'(rd), 32'h01);
    check("lit_kw_code", 32'(kw_code), 32'h01);

    // Seven keyword bytes with a matching length, then commit.
    load_keywords(7, 8'h07);
    pulses0 = commit_pulses;
    reg_wr(8'h37, 8'h04);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("lit_busy_len", 32'(n), 32'd64);
    check("lit_commit_once", 32'(commit_pulses - pulses0), 32'd1);
    check("lit_kw_count_7", 32'(kw_count), 32'd7);
    check("lit_len_err_0", 32'(len_err), 32'd0);
    for (int i = 0; i < 7; i++) check("kw_mem", 32'(dut.r_kw_mem[i]), 32'(8'h10 + i));

    // Status reads busy, then idle; a stored 0xB2 value is never read back.
    reg_wr(8'h37, 8'h00);
    reg_rd(8'hB2, rd);
    check("lit_b2_busy", 32'(rd), 32'h00);
    wait_idle();
    reg_rd(8'hB2, rd);
    check("lit_b2_idle", 32'(rd), 32'h21);
    reg_wr(8'hB2, 8'h55);
    reg_rd(8'hB2, rd);
    check("lit_b2_ignore", 32'(rd), 32'h21);

    // Rewrite of 0x37 about 30 cycles in extends busy.
    reg_wr(8'h37, 8'h00);
    repeat (26) @(negedge clk);
    reg_wr(8'h37, 8'h00);
    repeat (50) @(negedge clk);
    check("lit_busy_extended", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    check("lit_busy_done", 32'(busy), 32'd0);

    // Length mismatch sets a sticky len_err.
    load_keywords(7, 8'h09);
    reg_wr(8'h37, 8'h04);
    @(negedge clk);
    check("lit_len_err_1", 32'(len_err), 32'd1);
    reg_wr(8'hC1, 8'h22);
    reg_rd(8'hC1, rd);
    check("lit_rd_C1_22", 32'(rd), 32'h22);
    check("lit_len_sticky", 32'(len_err), 32'd1);
    wait_idle();

    // Data phase with no latched address.
    check("lit_proto_0", 32'(proto_err), 32'd0);
    reg_wr(8'h40, 8'h5A);
    bus_wr(1'b0, 8'hAA);
    @(negedge clk);
    check("lit_proto_1", 32'(proto_err), 32'd1);
    reg_rd(8'h40, rd);
    check("lit_rd_40", 32'(rd), 32'h5A);

    // FIFO overflow then clear.
    reg_wr(8'h08, 8'h04);
    for (int i = 0; i < 65; i++) reg_wr(8'h05, 8'(i));
    check("lit_kw_full", 32'(kw_count), 32'd64);
    check("lit_proto_ovf", 32'(proto_err), 32'd1);
    check("lit_kw_mem_last", 32'(dut.r_kw_mem[63]), 32'd63);
    reg_wr(8'h08, 8'h04);
    @(negedge clk);
    check("lit_kw_clear", 32'(kw_count), 32'd0);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ld3320_bus_responder.md
# ld3320_bus_responder

Synthesizable responder for the LD3320 parallel bus (A0/CSB/WRB/RDB plus 8-bit P). It emulates the chip side of the register interface: a 256×8 register file, a keyword FIFO behind register 0x05, and the 0xB2 busy/idle status register. It lets the host-side keyword-loading and recognition sequencers run in FPGA loopback and in simulation without a physical LD3320.

## Interface
- BUSY_CYCLES, 64: clk cycles for which 0xB2 reads busy after an ASR start (write to 0x37).
- KW_DEPTH, 64: keyword FIFO depth in bytes, power of two, maximum 128.
- clk  in  1  system clock; all bus pins are synchronous to it.
- sys_rstn  in  1  asynchronous, active-low reset.
- P  inout  8  data bus. Driven only while CSB=0, RDB=0 and A0=0; otherwise high-Z.
- A0  in  1  1 selects the address phase, 0 selects the data phase.
- CSB  in  1  chip select, active low.
- WRB  in  1  write strobe, active low; the transfer happens on its rising edge.
- RDB  in  1  read strobe, active low; the transfer completes on its rising edge.
- busy  out  1  busy counter is non-zero.
- kw_count  out  $clog2(KW_DEPTH)+1  number of bytes currently held in the keyword FIFO.
- kw_code  out  8  last value written to 0xC1.
- commit  out  1  one-cycle pulse when a write to 0x37 is accepted.
- len_err  out  1  sticky flag: at commit, 0xB9 differed from kw_count.
- proto_err  out  1  sticky flag: data phase seen with no latched address, or FIFO overflow.

## Operation
- Pin sampling: every cycle register WRB_d, RDB_d, CSB_d, A0_d and P_d. Reset values: WRB_d=1, RDB_d=1, CSB_d=1, A0_d=0, P_d=0.
- Write strobe: wr_evt = ~WRB_d & WRB & ~CSB_d. The written byte is P_d and the phase is A0_d.
- Read strobe: rd_evt = ~RDB_d & RDB & ~CSB_d.
- Bus FSM states: IDLE, ADDR, READ.
  - IDLE: wr_evt with A0_d=1 latches addr=P_d and goes to ADDR. wr_evt with A0_d=0, or RDB low with CSB=0 and A0=0, sets proto_err and stays in IDLE.
  - ADDR: wr_evt with A0_d=1 re-latches addr and stays in ADDR. wr_evt with A0_d=0 performs the register write and goes to IDLE. RDB low with CSB=0 and A0=0 goes to READ.
  - READ: rd_evt goes to IDLE. A write event while in READ sets proto_err and goes to IDLE.
- Read data is combinational on the pins: P = rd_data when CSB=0, RDB=0 and A0=0.
  - rd_data = 0x21 if addr=0xB2 and busy=0.
  - rd_data = 0x00 if addr=0xB2 and busy=1.
  - For any other address, rd_data = regfile[addr].
- Register write side effects, applied in addition to storing the value in regfile[addr]:
  - 0x05: push the byte into the keyword FIFO. If the FIFO is full, drop the byte and set proto_err.
  - 0x08: if data bit2=1, clear the FIFO (kw_count=0, pointers=0). If bit2=0, no side effect.
  - 0xC1: kw_code=data.
  - 0x37: pulse commit. Load busy_cnt=BUSY_CYCLES. Set len_err if regfile[0xB9] ≠ kw_count, compared zero-extended to 8 bits.
  - 0xB2: stored value is ignored on readback.
- Busy counter: decrements by 1 each cycle while non-zero. A new 0x37 write reloads it to BUSY_CYCLES, even mid-count.
- FIFO contents are not readable over the bus; they are exposed for the bench through a hierarchical reference only.
- len_err and proto_err are cleared only by reset.

## Timing
- Reset values: the FSM is in IDLE and P is high-Z.
- Reset values of outputs: busy=0, kw_count=0, kw_code=0x00, commit=0, len_err=0, proto_err=0.
- Reset value of the register file: all entries 0x00.
- A write takes effect 1 cycle after the WRB rising-edge sample. commit, kw_count and busy update in the same cycle as wr_evt is seen registered.
- Consequently, busy rises 1 cycle after the WRB rising edge and stays high for exactly BUSY_CYCLES cycles.
- Read data is valid on P in the same cycle RDB goes low, provided ADDR was reached at least 1 cycle earlier.
- The host must hold WRB low for at least 1 clk. Strobes shorter than that may be missed; this is required behaviour, not an error.
- Simultaneous FIFO clear and full condition: the clear wins.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and P is released asynchronously.

## Test plan
- Write 0xC1 with 0x01, then read 0xC1 → P=0x01 while RDB is low; kw_code=0x01.
- Write 0x08=0x04, then 0x05 ×7, then 0xB9=0x07, then 0x37=0x04 → kw_count=7; commit pulses once; len_err=0.
- Same sequence with 0xB9=0x09 → len_err=1 and stays set after further traffic.
- With BUSY_CYCLES=64: write 0x37, then poll 0xB2 → reads 0x00 for 64 cycles after busy rises, 0x21 afterwards. A rewrite of 0x37 at cycle 30 extends busy to 30+64.
- Data-phase write with no prior address phase → proto_err=1; regfile unchanged.
- 65 pushes to 0x05 with KW_DEPTH=64 → kw_count=64; proto_err=1. A following write of 0x08=0x04 → kw_count=0.
